rc4_decrypt_check: RTL and testbench

RC4 PRGA decrypt-and-validate stage. Once the key-schedule stage has filled the S array, this block generates the keystream, decrypts the ciphertext ROM into the decrypted-message RAM, and checks every plaintext byte for lowercase ASCII or space. It sits directly upstream of the brute-force key controller. It drives that controller's `finish_decrypt`/`valid` inputs, and its `restart` input is driven by the controller's `reset_pulse`.

---
 rtl/rc4_decrypt_check.sv | 185 ++++++++++++++++++
 tb/tb_rc4_decrypt_check.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_check.sv
// rc4_decrypt_check
//   RC4 PRGA decrypt-and-validate stage. After the key-schedule stage has
//   filled S, it generates the keystream and decrypts the ciphertext ROM into
//   the decrypted-message RAM. It also checks every plaintext byte for
//   lowercase ASCII (8'h61..8'h7A) or space (8'h20).
//
//   Each byte takes 9 states:
//     READ_I WAIT_I READ_J WAIT_J SWAP_I SWAP_J READ_F WAIT_F WRITE_D
//
//   All memory-side outputs are registered. An address is loaded on the edge
//   that enters a READ_* state, so the memory samples it at the end of that
//   state. The returned data is consumed on the edge that leaves the
//   following WAIT_* state.
//
//   Optional feature: define RC4_EARLY_ABORT_EN to stop the run at the first
//   illegal byte. That byte is still written to D. When the macro is
//   undefined, all MSG_LEN bytes are always processed.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   start               1-cycle pulse: S is ready, begin a run (IDLE or DONE)
//   restart             synchronous abort to IDLE; has priority over start
//   s_addr/s_wdata/s_wren/s_rdata     S RAM port (read latency 1)
//   rom_addr/rom_rdata                ciphertext ROM (read latency 1)
//   d_addr/d_wdata/d_wren             decrypted RAM write port
//   finish_decrypt      level, run complete
//   valid               level, all checked bytes legal (qualified by finish)
module rc4_decrypt_check #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              restart,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_rdata,
    output logic [ADDR_W-1:0] d_addr,
    output logic [7:0]        d_wdata,
    output logic              d_wren,
    output logic              finish_decrypt,
    output logic              valid
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, READ_I, WAIT_I, READ_J, WAIT_J,
        SWAP_I, SWAP_J, READ_F, WAIT_F, WRITE_D, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        i, j, si, sj;
    logic [ADDR_W-1:0] k;
    logic [7:0]        pt;
    logic              pt_ok;
    logic              last_byte;
    logic              stop_now;

    // In WAIT_F both f (s_rdata) and ROM[k] are on the read buses.
    assign pt        = s_rdata ^ rom_rdata;
    assign pt_ok     = (pt == 8'h20) || ((pt >= 8'h61) && (pt <= 8'h7A));
    assign last_byte = (k == K_LAST);

    // Evaluated in WRITE_D. By then, valid already includes this byte's check.
`ifdef RC4_EARLY_ABORT_EN
    assign stop_now = last_byte || !valid;
`else
    assign stop_now = last_byte;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nxt = READ_I;
                READ_I:     state_nxt = WAIT_I;
                WAIT_I:     state_nxt = READ_J;
                READ_J:     state_nxt = WAIT_J;
                WAIT_J:     state_nxt = SWAP_I;
                SWAP_I:     state_nxt = SWAP_J;
                SWAP_J:     state_nxt = READ_F;
                READ_F:     state_nxt = WAIT_F;
                WAIT_F:     state_nxt = WRITE_D;
                WRITE_D:    state_nxt = stop_now ? DONE : READ_I;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // Datapath and registered outputs. Each arm sets up the outputs for the
    // state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_addr         <= '0;
            s_wdata        <= '0;
            s_wren         <= 1'b0;
            rom_addr       <= '0;
            d_addr         <= '0;
            d_wdata        <= '0;
            d_wren         <= 1'b0;
            finish_decrypt <= 1'b0;
            valid          <= 1'b0;
            i              <= '0;
            j              <= '0;
            k              <= '0;
            si             <= '0;
            sj             <= '0;
        end else if (restart) begin
            // S is left partially permuted; the key-schedule stage refills it.
            s_wren         <= 1'b0;
            d_wren         <= 1'b0;
            finish_decrypt <= 1'b0;
            valid          <= 1'b0;
            i              <= '0;
            j              <= '0;
            k              <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // First byte uses i = 0 + 1.
                        finish_decrypt <= 1'b0;
                        valid          <= 1'b1;
                        i              <= 8'd1;
                        j              <= '0;
                        k              <= '0;
                        s_addr         <= 8'd1;
                    end
                end
                WAIT_I: begin
                    si     <= s_rdata;
                    j      <= j + s_rdata;
                    s_addr <= j + s_rdata;
                end
                WAIT_J: begin
                    sj      <= s_rdata;
                    s_addr  <= i;
                    s_wdata <= s_rdata;
                    s_wren  <= 1'b1;
                end
                SWAP_I: begin
                    // s_wren stays high for the second write. If i == j,
                    // this write lands last, so S[i] ends up holding si.
                    s_addr  <= j;
                    s_wdata <= si;
                end
                SWAP_J: begin
                    s_wren   <= 1'b0;
                    s_addr   <= si + sj;
                    rom_addr <= k;
                end
                WAIT_F: begin
                    d_addr  <= k;
                    d_wdata <= pt;
                    d_wren  <= 1'b1;
                    valid   <= valid & pt_ok;
                end
                WRITE_D: begin
                    d_wren <= 1'b0;
                    if (stop_now) begin
                        finish_decrypt <= 1'b1;
                    end else begin
                        i      <= i + 8'd1;
                        k      <= k + 1'b1;
                        s_addr <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_decrypt_check.sv
module tb_rc4_decrypt_check;

    localparam int MSG_LEN = 4;
    localparam int ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              restart = 1'b0;
    logic [7:0]        s_addr, s_wdata, s_rdata;
    logic              s_wren;
    logic [ADDR_W-1:0] rom_addr, d_addr;
    logic [7:0]        rom_rdata, d_wdata;
    logic              d_wren, finish_decrypt, valid;

    logic [7:0] smem [256];
    logic [7:0] rom  [32];
    logic [7:0] dmem [32];
    logic       s_load = 1'b0;
    logic       d_clr  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    rc4_decrypt_check #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .restart(restart),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_wren(d_wren),
        .finish_decrypt(finish_decrypt), .valid(valid)
    );

    always #5 clk = ~clk;

    // Synchronous memory models: address sampled at the edge, data valid the
    // following cycle.
    always @(posedge clk) begin
        if (s_load) begin
            for (int x = 0; x < 256; x++) smem[x] <= 8'(x);
        end else if (s_wren) begin
            smem[s_addr] <= s_wdata;
        end
        s_rdata   <= smem[s_addr];
        rom_rdata <= rom[rom_addr];
    end

    always @(posedge clk) begin
        if (d_clr) begin
            for (int x = 0; x < 32; x++) dmem[x] <= 8'hEE;
        end else if (d_wren) begin
            dmem[d_addr] <= d_wdata;
        end
    end

    logic [37:0] out_vec;
    assign out_vec = {s_addr, s_wdata, s_wren, rom_addr, d_addr, d_wdata,
                      d_wren, finish_decrypt, valid};

    // Load identity S and fill D with 8'hEE, so unwritten bytes are visible.
    task automatic prep();
        @(negedge clk);
        s_load = 1'b1;
        d_clr  = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
        d_clr  = 1'b0;
    endtask

    task automatic set_rom(input logic [7:0] b0, b1, b2, b3);
        for (int x = 0; x < 32; x++) rom[x] = 8'h00;
        rom[0] = b0; rom[1] = b1; rom[2] = b2; rom[3] = b3;
    endtask

    // Pulse start. fin0 is finish_decrypt just after the start edge; n is the
    // number of edges until finish is seen (capped at 400).
    task automatic run(output int n, output logic fin0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fin0 = finish_decrypt;
        n = 0;
        while (finish_decrypt !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (out_vec !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", out_vec);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_identity();
        int n; logic f0;
        logic [7:0] exp_d [4];
        logic [7:0] s_idx [5];
        logic [7:0] s_exp [5];
        exp_d = '{8'h61, 8'h62, 8'h63, 8'h64};
        s_idx = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd9};
        s_exp = '{8'h03, 8'h05, 8'h09, 8'h02, 8'h04};
        prep();
        set_rom(8'h63, 8'h67, 8'h64, 8'h69);
        run(n, f0);
        n_cmp++;
        if (n != 36) begin n_bad++; $display("FAIL identity_finish_edge: got %0d want 36", n); end
        n_cmp++;
        if (valid !== 1'b1) begin n_bad++; $display("FAIL identity_valid: got %b want 1", valid); end
        for (int x = 0; x < 4; x++) begin
            n_cmp++;
            if (dmem[x] !== exp_d[x]) begin
                n_bad++;
                $display("FAIL identity_D%0d: got %h want %h", x, dmem[x], exp_d[x]);
            end
        end
        for (int x = 0; x < 5; x++) begin
            n_cmp++;
            if (smem[s_idx[x]] !== s_exp[x]) begin
                n_bad++;
                $display("FAIL identity_S%0d: got %h want %h", s_idx[x], smem[s_idx[x]], s_exp[x]);
            end
        end
    endtask

    task automatic test_illegal();
        int n; logic f0;
        int exp_n;
        logic [7:0] exp_d3;
`ifdef RC4_EARLY_ABORT_EN
        exp_n = 27; exp_d3 = 8'hEE;
`else
        exp_n = 36; exp_d3 = 8'h64;
`endif
        prep();
        set_rom(8'h63, 8'h67, 8'h46, 8'h69);
        run(n, f0);
        n_cmp++;
        if (n != exp_n) begin n_bad++; $display("FAIL illegal_finish_edge: got %0d want %0d", n, exp_n); end
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL illegal_valid: got %b want 0", valid); end
        n_cmp++;
        if (dmem[2] !== 8'h41) begin n_bad++; $display("FAIL illegal_D2: got %h want 41", dmem[2]); end
        n_cmp++;
        if (dmem[3] !== exp_d3) begin n_bad++; $display("FAIL illegal_D3: got %h want %h", dmem[3], exp_d3); end
    endtask

    // Keystream under identity S is 02,05,07,0D.
    task automatic test_boundaries();
        int n; logic f0;
        int exp_n;
        logic [7:0] bad_rom [3];
        logic [7:0] bad_pt  [3];
        bad_rom = '{8'h1A, 8'h65, 8'h7E};
        bad_pt  = '{8'h1F, 8'h60, 8'h7B};
        // Plaintext 20,61,7A,20: every byte is legal.
        prep();
        set_rom(8'h22, 8'h64, 8'h7D, 8'h2D);
        run(n, f0);
        n_cmp++;
        if (n != 36 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bound_pass: edge %0d valid %b want 36 1", n, valid);
        end
`ifdef RC4_EARLY_ABORT_EN
        exp_n = 18;
`else
        exp_n = 36;
`endif
        for (int x = 0; x < 3; x++) begin
            prep();
            set_rom(8'h63, bad_rom[x], 8'h64, 8'h69);
            run(n, f0);
            n_cmp++;
            if (n != exp_n || valid !== 1'b0) begin
                n_bad++;
                $display("FAIL bound_%h: edge %0d valid %b want %0d 0", bad_pt[x], n, valid, exp_n);
            end
        end
    endtask

    // DUT is in DONE here; restart must win over start.
    task automatic test_restart_start();
        int wr = 0;
        @(negedge clk);
        restart = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        start   = 1'b0;
        n_cmp++;
        if (finish_decrypt !== 1'b0 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_start_flags: fin %b valid %b want 0 0", finish_decrypt, valid);
        end
        repeat (20) begin
            @(posedge clk); #1;
            if (s_wren || d_wren || finish_decrypt) wr++;
        end
        n_cmp++;
        if (wr != 0) begin n_bad++; $display("FAIL restart_start_idle: active cycles %0d want 0", wr); end
    endtask

    task automatic test_restart_mid();
        int wr = 0;
        prep();
        set_rom(8'h63, 8'h67, 8'h64, 8'h69);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        repeat (60) begin
            if (s_wren || d_wren || finish_decrypt) wr++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (wr != 0) begin n_bad++; $display("FAIL restart_mid_quiet: active cycles %0d want 0", wr); end
        n_cmp++;
        if (dmem[1] !== 8'hEE) begin n_bad++; $display("FAIL restart_mid_D1: got %h want EE", dmem[1]); end
    endtask

    task automatic test_async_reset();
        int n; logic f0;
        prep();
        set_rom(8'h63, 8'h67, 8'h64, 8'h69);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (s_wren !== 1'b1) begin n_bad++; $display("FAIL async_pre_swap: s_wren %b want 1", s_wren); end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (out_vec !== 38'd0) begin n_bad++; $display("FAIL async_outputs: got %h want 0", out_vec); end
        @(negedge clk);
        rst = 1'b1;
        prep();
        run(n, f0);
        n_cmp++;
        if (n != 36 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL async_rerun: edge %0d valid %b want 36 1", n, valid);
        end
        n_cmp++;
        if ({dmem[0], dmem[1], dmem[2], dmem[3]} !== 32'h61626364) begin
            n_bad++;
            $display("FAIL async_rerun_D: got %h%h%h%h want 61626364", dmem[0], dmem[1], dmem[2], dmem[3]);
        end
    endtask

    task automatic test_rerun_from_done();
        int n; logic f0;
        n_cmp++;
        if (finish_decrypt !== 1'b1) begin n_bad++; $display("FAIL rerun_pre_done: fin %b want 1", finish_decrypt); end
        prep();
        run(n, f0);
        n_cmp++;
        if (f0 !== 1'b0) begin n_bad++; $display("FAIL rerun_fin_drop: fin %b want 0", f0); end
        n_cmp++;
        if (n != 36 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rerun_finish: edge %0d valid %b want 36 1", n, valid);
        end
        n_cmp++;
        if (dmem[3] !== 8'h64) begin n_bad++; $display("FAIL rerun_D3: got %h want 64", dmem[3]); end
    endtask

    initial begin
        for (int x = 0; x < 32; x++) rom[x] = 8'h00;
        test_reset();
        test_identity();
        test_illegal();
        test_boundaries();
        test_restart_start();
        test_restart_mid();
        test_async_reset();
        test_rerun_from_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
